hazard_ctrl: RTL

Pipeline control unit for the 16-bit five-stage datapath. It sequences the IF/ID pipeline register and PC update through `IFIDWrite`, `PCWrite` and `flush`, and injects bubbles into ID/EX. It resolves four conditions:
- load-use hazards
- taken-branch squashes
- multi-cycle EX operations (multiply/divide)
- halt/resume

It sits beside the IF/ID and ID/EX registers and is their only source of write-enable and flush control.

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_ctrl_load_use_detect.sv | 19 +
 rtl/hazard_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: controller state
// encoding, default register-address width and the NOP encoding that the
// IF/ID flush logic loads.
package pipe_ctrl_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_HALTED   = 2'd2
    } state_e;

    // Default register-address width of the 16-bit datapath
    localparam int REG_AW = 4;

    // Instruction word placed in IF/ID when it is flushed
    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: flags when the load in EX writes a
// register that the instruction in ID reads. Register zero never hazards.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0] ifid_rs_i,
    input  logic [AW-1:0] ifid_rt_i,
    input  logic [AW-1:0] idex_rt_i,
    input  logic          idex_mem_read_i,
    output logic          hazard_o
);

    assign hazard_o = idex_mem_read_i
                   && (idex_rt_i != '0)
                   && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline control unit: drives IF/ID / PC write enables, IF/ID flush,
// ID/EX bubble and EX hold for load-use, taken branch, multi-cycle EX ops
// and halt/resume.
// Optional statistics counters are built when HAZARD_CTRL_STATS_EN is defined.
// dbg_state_o exposes the controller state for observation.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int REG_AW     = pipe_ctrl_pkg::REG_AW,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ifid_rs,
    input  logic [REG_AW-1:0] ifid_rt,
    input  logic [REG_AW-1:0] idex_rt,
    input  logic              idex_memRead,
    input  logic              branch_taken,
    input  logic              mul_start,
    input  logic              halt,
    input  logic              resume,
    output logic              IFIDWrite,
    output logic              PCWrite,
    output logic              flush,
    output logic              idex_bubble,
    output logic              ex_hold,
    output state_e            dbg_state_o
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    localparam int              CW       = $clog2(MUL_CYCLES) + 1;
    localparam bit              MUL_EN   = (MUL_CYCLES > 1);
    localparam logic [CW-1:0]   MUL_LOAD = CW'(MUL_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] mul_cnt_q, mul_cnt_d;
    logic          load_use;

    load_use_detect #(
        .AW(REG_AW)
    ) u_load_use_detect (
        .ifid_rs_i       (ifid_rs),
        .ifid_rt_i       (ifid_rt),
        .idex_rt_i       (idex_rt),
        .idex_mem_read_i (idex_memRead),
        .hazard_o        (load_use)
    );

    // State and multi-cycle counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Next-state logic; priority in RUN is branch, mul_start, load-use, halt
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (!branch_taken) begin
                    if (mul_start && MUL_EN) begin
                        state_d   = ST_MUL_BUSY;
                        mul_cnt_d = MUL_LOAD;
                    end else if (!load_use && halt) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_MUL_BUSY: begin
                // Counter reading 1 is the last busy cycle; <= guards a stray 0
                if (mul_cnt_q <= CW'(1)) begin
                    state_d   = ST_RUN;
                    mul_cnt_d = '0;
                end else begin
                    mul_cnt_d = mul_cnt_q - CW'(1);
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d   = ST_RUN;
                mul_cnt_d = '0;
            end
        endcase
    end

    // Output decode from state and inputs; reset forces the squash pattern
    always_comb begin
        IFIDWrite   = 1'b0;
        PCWrite     = 1'b0;
        flush       = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    IFIDWrite   = 1'b1;
                    PCWrite     = 1'b1;
                    flush       = 1'b1;
                    idex_bubble = 1'b1;
                end else if (mul_start && MUL_EN) begin
                    IFIDWrite = 1'b1;
                    PCWrite   = 1'b1;
                end else if (load_use || halt) begin
                    idex_bubble = 1'b1;
                end else begin
                    IFIDWrite = 1'b1;
                    PCWrite   = 1'b1;
                end
            end
            ST_MUL_BUSY: begin
                ex_hold = 1'b1;
            end
            ST_HALTED: begin
                idex_bubble = 1'b1;
            end
            default: begin
                idex_bubble = 1'b1;
            end
        endcase
        if (reset) begin
            IFIDWrite   = 1'b0;
            PCWrite     = 1'b0;
            flush       = 1'b1;
            idex_bubble = 1'b1;
            ex_hold     = 1'b0;
        end
    end

    assign dbg_state_o = state_q;

`ifdef HAZARD_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating counters of stalled-PC cycles and flush cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!PCWrite && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`endif

endmodule
